multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 Parameter TRAP_EN, default 1: 1 sends illegal opcodes to TRAP; 0 executes them as NOP.
REQ-003 Parameter ALUCTR_W, default 5: width of alu_ctr.
REQ-004 clk input 1: the block has one clock; all state changes on its rising edge.
REQ-005 rst_n input 1: reset is asynchronous and active-low.
REQ-006 imem_ack input 1: instruction word valid on imem_rdata this cycle.
REQ-007 imem_rdata input 32: fetched instruction.
REQ-008 dmem_ack input 1: data access complete this cycle.
REQ-009 br_taken input 1: ALU compare result, valid in EXEC.
REQ-010 imem_req output 1: instruction fetch request.
REQ-011 dmem_req output 1: data access request.
REQ-012 dmem_we output 1: data access is a store.
REQ-013 ir_we output 1: latch the instruction register.
REQ-014 pc_we output 1: update PC.
REQ-015 pc_sel output 2: next-PC source; 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1.
REQ-016 reg_we output 1: register-file write strobe.
REQ-017 wb_sel output 2: write-back source; 00 ALU, 01 memory, 10 pc+4.
REQ-018 alu_a_sel output 1: 0 rs1, 1 PC.
REQ-019 alu_b_sel output 1: 0 rs2, 1 immediate.
REQ-020 alu_ctr output ALUCTR_W: ALU operation code.
REQ-021 ext_op output 3: immediate format; I 000, B 001, J 010, S 011, U 100.
REQ-022 mem_op output 3: access size; b 000, bu 001, h 010, hu 011, w 100.
REQ-023 trap output 1: illegal instruction detected; sticky.

Function
REQ-024 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-025 FETCH SHALL assert imem_req until imem_ack; on ack it SHALL pulse ir_we and go to DECODE.
REQ-026 DECODE SHALL register alu_ctr, ext_op, mem_op, alu_a_sel, alu_b_sel and wb_sel from the instruction register; these SHALL then hold until the next DECODE.
REQ-027 alu_ctr codes SHALL be: add 0, sll 1, slt 2, sltu 3, xor 4, srl 5, or 6, and 7, sub 8, sra 9, beq 10, bne 11, blt 12, bge 13, bltu 14, bgeu 15, lui-pass-B 16.
REQ-028 Operand selection SHALL be: I-type, load, store and jalr use rs1+imm; auipc and jal use PC+imm; lui uses pass-B with imm.
REQ-029 Legal opcodes SHALL be 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0010111 and 0110111; funct7 SHALL be checked for R-type, slli, srli and srai.
REQ-030 An illegal encoding with TRAP_EN=1 SHALL go DECODE->TRAP; with TRAP_EN=0 it SHALL go DECODE->WB with reg_we=0.
REQ-031 EXEC SHALL last one cycle; loads and stores SHALL then go to MEM, branches to FETCH, and all other instructions to WB.
REQ-032 A branch in EXEC SHALL pulse pc_we with pc_sel=01 if br_taken and 00 otherwise; reg_we SHALL stay 0.
REQ-033 MEM SHALL hold dmem_req, and dmem_we for stores, until dmem_ack; a store SHALL then go to FETCH with pc_we and pc_sel=00, and a load SHALL go to WB.
REQ-034 WB SHALL pulse reg_we for one cycle except for stores, branches and illegal-NOP.
REQ-035 WB SHALL pulse pc_we: jal pc_sel=01, jalr 10, others 00; jal and jalr SHALL use wb_sel=10; WB SHALL then go to FETCH.
REQ-036 TRAP SHALL be absorbing: trap=1 and all strobes 0 until reset.
REQ-037 Strobes (imem_req, dmem_req, ir_we, pc_we, reg_we) SHALL be Moore outputs of the state, except the ack-qualified ir_we in FETCH and pc_we in MEM.
REQ-038 An ack arriving in any state other than the one waiting for it SHALL be ignored.
REQ-039 Best-case instruction latency SHALL be: ALU 4 cycles, branch 3, store 4, load 5, each with zero-wait acks.

Reset
REQ-040 While rst_n=0 the state SHALL be FETCH, all strobes 0, trap=0, all registered decode fields 0, and pc_sel=00.
REQ-041 Reset asserted mid-operation SHALL abort any outstanding request within that cycle; imem_req SHALL assert on the first clk after rst_n rises.

Verification
REQ-042 Stimulus: addi x1,x0,5 (0x00500093) with zero-wait acks -> response: alu_ctr=0, ext_op=000, alu_b_sel=1, reg_we pulses in cycle 4, pc_we with pc_sel=00.
REQ-043 Stimulus: lw x2,4(x1) (0x0040A103) with dmem_ack delayed 3 cycles -> response: dmem_req high 4 cycles, dmem_we=0, mem_op=100, wb_sel=01, a single reg_we pulse.
REQ-044 Stimulus: beq (0x00000463) with br_taken=1, then repeated with br_taken=0 -> response: pc_sel=01 then 00, reg_we never asserted, 3 cycles each.
REQ-045 Stimulus: sb (0x00108023) -> response: dmem_we=1, mem_op=000, no reg_we, then return to FETCH.
REQ-046 Stimulus: instruction 0xFFFFFFFF -> response: with TRAP_EN=1, trap=1 sticky and imem_req stays 0; with TRAP_EN=0, PC advances and reg_we=0.
REQ-047 Stimulus: rst_n pulsed low while in MEM with dmem_req high -> response: dmem_req drops asynchronously, FSM restarts in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I core: decodes the fetched instruction and
// sequences fetch, execute, data-memory and write-back strobes for the datapath.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          TRAP_EN  = 1'b1,
  parameter int          ALUCTR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                dmem_ack,
  input  logic                br_taken,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                alu_a_sel,
  output logic                alu_b_sel,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic [2:0]          ext_op,
  output logic [2:0]          mem_op,
  output logic                trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_ILL
  } kind_t;

  state_t      r_state, w_next;
  logic        r_run;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  kind_t       r_kind, w_kind;
  logic [4:0]  r_alu, w_alu;
  logic [2:0]  r_ext, w_ext;
  logic [2:0]  r_mem, w_mem;
  logic        r_a, w_a;
  logic        r_b, w_b;
  logic [1:0]  r_wb, w_wb;
  logic        w_legal;

  // Register/immediate fields are consumed by the datapath, and the reset PC
  // is loaded there too; the controller only needs opcode, funct3 and funct7.
  logic w_unused;
  assign w_unused = ^{imem_rdata[24:15], imem_rdata[11:7], RESET_PC};

  // r_run keeps imem_req low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_funct3 <= '0;
      r_funct7 <= '0;
    end else if (ir_we) begin
      r_opcode <= imem_rdata[6:0];
      r_funct3 <= imem_rdata[14:12];
      r_funct7 <= imem_rdata[31:25];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind <= K_ALU;
      r_alu  <= '0;
      r_ext  <= '0;
      r_mem  <= '0;
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_wb   <= '0;
    end else if (r_state == S_DECODE) begin
      r_kind <= w_kind;
      r_alu  <= w_alu;
      r_ext  <= w_ext;
      r_mem  <= w_mem;
      r_a    <= w_a;
      r_b    <= w_b;
      r_wb   <= w_wb;
    end
  end

  always_comb begin
    w_legal = 1'b1;
    w_kind  = K_ALU;
    w_alu   = 5'd0;
    w_ext   = 3'b000;
    w_mem   = 3'b000;
    w_a     = 1'b0;
    w_b     = 1'b0;
    w_wb    = 2'b00;
    case (r_opcode)
      7'b0110011: begin
        w_alu = {2'b00, r_funct3};
        if (r_funct7 == 7'b0100000 && r_funct3 == 3'b000) w_alu = 5'd8;
        else if (r_funct7 == 7'b0100000 && r_funct3 == 3'b101) w_alu = 5'd9;
        else if (r_funct7 != 7'b0000000) w_legal = 1'b0;
      end
      7'b0010011: begin
        w_alu = {2'b00, r_funct3};
        w_b   = 1'b1;
        if (r_funct3 == 3'b001 && r_funct7 != 7'b0000000) w_legal = 1'b0;
        if (r_funct3 == 3'b101) begin
          if (r_funct7 == 7'b0100000) w_alu = 5'd9;
          else if (r_funct7 != 7'b0000000) w_legal = 1'b0;
        end
      end
      7'b0000011: begin
        w_kind = K_LOAD;
        w_b    = 1'b1;
        w_wb   = 2'b01;
        case (r_funct3)
          3'b000:  w_mem = 3'b000;
          3'b001:  w_mem = 3'b010;
          3'b010:  w_mem = 3'b100;
          3'b100:  w_mem = 3'b001;
          3'b101:  w_mem = 3'b011;
          default: w_legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        w_kind = K_STORE;
        w_b    = 1'b1;
        w_ext  = 3'b011;
        case (r_funct3)
          3'b000:  w_mem = 3'b000;
          3'b001:  w_mem = 3'b010;
          3'b010:  w_mem = 3'b100;
          default: w_legal = 1'b0;
        endcase
      end
      7'b1100011: begin
        w_kind = K_BRANCH;
        w_ext  = 3'b001;
        case (r_funct3)
          3'b000:  w_alu = 5'd10;
          3'b001:  w_alu = 5'd11;
          3'b100:  w_alu = 5'd12;
          3'b101:  w_alu = 5'd13;
          3'b110:  w_alu = 5'd14;
          3'b111:  w_alu = 5'd15;
          default: w_legal = 1'b0;
        endcase
      end
      7'b1100111: begin
        w_kind = K_JALR;
        w_b    = 1'b1;
        w_wb   = 2'b10;
        if (r_funct3 != 3'b000) w_legal = 1'b0;
      end
      7'b1101111: begin
        w_kind = K_JAL;
        w_a    = 1'b1;
        w_b    = 1'b1;
        w_ext  = 3'b010;
        w_wb   = 2'b10;
      end
      7'b0010111: begin
        w_a   = 1'b1;
        w_b   = 1'b1;
        w_ext = 3'b100;
      end
      7'b0110111: begin
        w_alu = 5'd16;
        w_b   = 1'b1;
        w_ext = 3'b100;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) w_kind = K_ILL;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (r_run && imem_ack) w_next = S_DECODE;
      S_DECODE: begin
        if (w_kind == K_ILL) w_next = TRAP_EN ? S_TRAP : S_WB;
        else                 w_next = S_EXEC;
      end
      S_EXEC: begin
        if (r_kind == K_LOAD || r_kind == K_STORE) w_next = S_MEM;
        else if (r_kind == K_BRANCH)               w_next = S_FETCH;
        else                                       w_next = S_WB;
      end
      S_MEM:  if (dmem_ack) w_next = (r_kind == K_STORE) ? S_FETCH : S_WB;
      S_WB:   w_next = S_FETCH;
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    reg_we   = 1'b0;
    trap     = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = r_run;
        ir_we    = r_run & imem_ack;
      end
      S_EXEC: begin
        if (r_kind == K_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_kind == K_STORE);
        pc_we    = (r_kind == K_STORE) & dmem_ack;
      end
      S_WB: begin
        pc_we  = 1'b1;
        reg_we = (r_kind != K_ILL);
        if (r_kind == K_JAL)       pc_sel = 2'b01;
        else if (r_kind == K_JALR) pc_sel = 2'b10;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign alu_ctr   = ALUCTR_W'(r_alu);
  assign ext_op    = r_ext;
  assign mem_op    = r_mem;
  assign alu_a_sel = r_a;
  assign alu_b_sel = r_b;
  assign wb_sel    = r_wb;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (TRAP_EN=1 and 0) share
// stimulus and run in lockstep until an illegal instruction splits them.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_ack;
  logic        br_taken;

  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_a_sel, alu_b_sel, trap;
  logic [1:0] pc_sel, wb_sel;
  logic [4:0] alu_ctr;
  logic [2:0] ext_op, mem_op;

  logic       nt_imem_req, nt_dmem_req, nt_dmem_we, nt_ir_we, nt_pc_we, nt_reg_we;
  logic       nt_alu_a_sel, nt_alu_b_sel, nt_trap;
  logic [1:0] nt_pc_sel, nt_wb_sel;
  logic [4:0] nt_alu_ctr;
  logic [2:0] nt_ext_op, nt_mem_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_PC(32'h0), .TRAP_EN(1'b1), .ALUCTR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_ack(dmem_ack), .br_taken(br_taken), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_ctr(alu_ctr), .ext_op(ext_op), .mem_op(mem_op),
    .trap(trap)
  );

  multicycle_ctrl #(.RESET_PC(32'h0), .TRAP_EN(1'b0), .ALUCTR_W(5)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_ack(dmem_ack), .br_taken(br_taken), .imem_req(nt_imem_req),
    .dmem_req(nt_dmem_req), .dmem_we(nt_dmem_we), .ir_we(nt_ir_we), .pc_we(nt_pc_we),
    .pc_sel(nt_pc_sel), .reg_we(nt_reg_we), .wb_sel(nt_wb_sel), .alu_a_sel(nt_alu_a_sel),
    .alu_b_sel(nt_alu_b_sel), .alu_ctr(nt_alu_ctr), .ext_op(nt_ext_op), .mem_op(nt_mem_op),
    .trap(nt_trap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter in FETCH just after an edge; leave in the state following DECODE.
  task automatic fetch_instr(input logic [31:0] ins);
    imem_rdata = ins;
    imem_ack   = 1'b1;
    #1;
    chk("fetch_imem_req", imem_req, 1);
    chk("fetch_ir_we", ir_we, 1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("decode_imem_req", imem_req, 0);
    chk("decode_ir_we", ir_we, 0);
    tick();
  endtask

  task automatic run_wb(input string tag, input logic [31:0] ins, input logic [4:0] e_alu,
                        input logic [2:0] e_ext, input logic e_a, input logic e_b,
                        input logic [1:0] e_wb, input logic [1:0] e_pcsel);
    fetch_instr(ins);
    dmem_ack = 1'b1;
    #1;
    chk({tag, "_alu_ctr"}, alu_ctr, e_alu);
    chk({tag, "_ext_op"}, ext_op, e_ext);
    chk({tag, "_alu_a_sel"}, alu_a_sel, e_a);
    chk({tag, "_alu_b_sel"}, alu_b_sel, e_b);
    chk({tag, "_exec_reg_we"}, reg_we, 0);
    chk({tag, "_exec_pc_we"}, pc_we, 0);
    chk({tag, "_exec_dmem_req"}, dmem_req, 0);
    tick();
    #1;
    chk({tag, "_wb_reg_we"}, reg_we, 1);
    chk({tag, "_wb_pc_we"}, pc_we, 1);
    chk({tag, "_wb_pc_sel"}, pc_sel, e_pcsel);
    chk({tag, "_wb_sel"}, wb_sel, e_wb);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk({tag, "_next_imem_req"}, imem_req, 1);
    chk({tag, "_next_reg_we"}, reg_we, 0);
  endtask

  task automatic run_branch(input logic taken, input logic [1:0] e_pcsel);
    fetch_instr(32'h0000_0463);
    br_taken = taken;
    #1;
    chk("beq_alu_ctr", alu_ctr, 10);
    chk("beq_ext_op", ext_op, 3'b001);
    chk("beq_alu_b_sel", alu_b_sel, 0);
    chk("beq_pc_we", pc_we, 1);
    chk("beq_pc_sel", pc_sel, e_pcsel);
    chk("beq_reg_we", reg_we, 0);
    tick();
    br_taken = 1'b0;
    #1;
    chk("beq_back_fetch", imem_req, 1);
    chk("beq_after_reg_we", reg_we, 0);
    chk("beq_after_pc_we", pc_we, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    br_taken   = 1'b0;
    #12;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_trap", trap, 0);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_alu_ctr", alu_ctr, 0);
    chk("rst_ext_op", ext_op, 0);
    chk("rst_mem_op", mem_op, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_alu_b_sel", alu_b_sel, 0);

    // Reset released mid-cycle: no fetch until the next clock edge.
    rst_n      = 1'b1;
    imem_rdata = 32'h0050_0093;
    imem_ack   = 1'b1;
    #1;
    chk("post_rst_imem_req", imem_req, 0);
    chk("post_rst_ir_we", ir_we, 0);
    tick();

    run_wb("addi", 32'h0050_0093, 5'd0, 3'b000, 1'b0, 1'b1, 2'b00, 2'b00);
    run_wb("sub", 32'h4000_0033, 5'd8, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00);
    run_wb("srai", 32'h4000_5013, 5'd9, 3'b000, 1'b0, 1'b1, 2'b00, 2'b00);
    run_wb("lui", 32'h0000_00B7, 5'd16, 3'b100, 1'b0, 1'b1, 2'b00, 2'b00);
    run_wb("jal", 32'h0000_006F, 5'd0, 3'b010, 1'b1, 1'b1, 2'b10, 2'b01);

    // lw with three wait cycles on the data ack
    fetch_instr(32'h0040_A103);
    #1;
    chk("lw_mem_op", mem_op, 3'b100);
    chk("lw_wb_sel", wb_sel, 2'b01);
    chk("lw_alu_b_sel", alu_b_sel, 1);
    chk("lw_exec_dmem_req", dmem_req, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      chk("lw_dmem_req", dmem_req, 1);
      chk("lw_dmem_we", dmem_we, 0);
      chk("lw_mem_reg_we", reg_we, 0);
      chk("lw_mem_pc_we", pc_we, 0);
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    chk("lw_wb_reg_we", reg_we, 1);
    chk("lw_wb_dmem_req", dmem_req, 0);
    chk("lw_wb_pc_we", pc_we, 1);
    chk("lw_wb_pc_sel", pc_sel, 0);
    tick();
    #1;
    chk("lw_next_reg_we", reg_we, 0);
    chk("lw_next_imem_req", imem_req, 1);

    run_branch(1'b1, 2'b01);
    run_branch(1'b0, 2'b00);

    // sb with a zero-wait data ack
    fetch_instr(32'h0010_8023);
    #1;
    chk("sb_mem_op", mem_op, 3'b000);
    chk("sb_ext_op", ext_op, 3'b011);
    chk("sb_exec_pc_we", pc_we, 0);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("sb_dmem_req", dmem_req, 1);
    chk("sb_dmem_we", dmem_we, 1);
    chk("sb_pc_we", pc_we, 1);
    chk("sb_pc_sel", pc_sel, 0);
    chk("sb_reg_we", reg_we, 0);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("sb_back_fetch", imem_req, 1);
    chk("sb_after_dmem_req", dmem_req, 0);
    chk("sb_after_reg_we", reg_we, 0);

    // Illegal word: trapping instance locks up, the other retires it as a NOP
    fetch_instr(32'hFFFF_FFFF);
    #1;
    chk("ill_trap", trap, 1);
    chk("ill_imem_req", imem_req, 0);
    chk("ill_pc_we", pc_we, 0);
    chk("nt_ill_trap", nt_trap, 0);
    chk("nt_ill_reg_we", nt_reg_we, 0);
    chk("nt_ill_pc_we", nt_pc_we, 1);
    chk("nt_ill_pc_sel", nt_pc_sel, 0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    tick();
    #1;
    chk("nt_ill_next_fetch", nt_imem_req, 1);
    for (int i = 0; i < 3; i++) begin
      chk("trap_sticky", trap, 1);
      chk("trap_imem_req", imem_req, 0);
      chk("trap_ir_we", ir_we, 0);
      chk("trap_dmem_req", dmem_req, 0);
      chk("trap_reg_we", reg_we, 0);
      tick();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("trap_cleared", trap, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted while a load waits in MEM
    fetch_instr(32'h0040_A103);
    tick();
    #1;
    chk("rmem_dmem_req", dmem_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmem_dmem_req_drop", dmem_req, 0);
    chk("rmem_imem_req", imem_req, 0);
    chk("rmem_mem_op", mem_op, 0);
    chk("rmem_wb_sel", wb_sel, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rmem_hold_imem_req", imem_req, 0);
    tick();
    chk("rmem_restart_fetch", imem_req, 1);
    chk("rmem_restart_dmem_req", dmem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
